// File: rtl/ahblite_master_engine_if.sv
// Command, response and AHB-Lite signal bundle for ahblite_master_engine.
// The master modport is the engine's view. The slave modport is the view of the command source, bus slave and response sink.
interface ahblite_master_engine_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, HREADY, HRESP, HRDATA,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, HREADY, HRESP, HRDATA,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA
    );
endinterface

// File: rtl/ahblite_master_engine.sv
// Single-word AHB-Lite initiator with a two-slot pipeline: address phase (AP) and data phase (DP).
// Define AHBM_TIMEOUT_EN to add the per-data-phase wait-state timeout.
module ahblite_master_engine #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                     HCLK,
    input logic                     HRESET,
    ahblite_master_engine_if.master bus
);

    // Each encoding is {AP valid, DP valid}.
    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_DATA      = 2'b01,
        S_ADDR      = 2'b10,
        S_ADDR_DATA = 2'b11
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_e      state_q, state_d;
    logic [31:0] ap_addr_q, ap_addr_d;
    logic        ap_write_q, ap_write_d;
    logic [31:0] ap_wdata_q, ap_wdata_d;
    logic        dp_write_q, dp_write_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic ap_valid, dp_valid, ap_valid_d, dp_valid_d;
    logic err_hold, adv, retire, accept, cmd_ready, tmo;

    logic [1:0] unused_addr_lsb;
    assign unused_addr_lsb = bus.cmd_addr[1:0];

`ifdef AHBM_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 255) ? 16 : 8;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;

    assign tmo = dp_valid && !bus.HREADY && (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (adv) begin
            wait_cnt_d = '0;
        end else if (dp_valid && !bus.HREADY) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT_CYCLES);
    assign tmo = 1'b0;
`endif

    assign ap_valid = (state_q == S_ADDR) || (state_q == S_ADDR_DATA);
    assign dp_valid = (state_q == S_DATA) || (state_q == S_ADDR_DATA);

    // An ERROR from the slave freezes AP for both error cycles so the cancelled address re-issues afterwards.
    assign err_hold  = dp_valid && bus.HRESP;
    assign adv       = bus.HREADY && !err_hold;
    assign retire    = dp_valid && bus.HREADY;
    assign cmd_ready = !HRESET && !tmo && (!ap_valid || adv);
    assign accept    = bus.cmd_valid && cmd_ready;

    always_comb begin
        ap_valid_d  = ap_valid;
        dp_valid_d  = dp_valid;
        ap_addr_d   = ap_addr_q;
        ap_write_d  = ap_write_q;
        ap_wdata_d  = ap_wdata_q;
        dp_write_d  = dp_write_q;
        hwdata_d    = hwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        if (adv) begin
            dp_valid_d = ap_valid;
            dp_write_d = ap_write_q;
            if (ap_valid && ap_write_q) begin
                hwdata_d = ap_wdata_q;
            end
            ap_valid_d = 1'b0;
        end else if (retire) begin
            dp_valid_d = 1'b0;
        end

        if (accept) begin
            ap_valid_d = 1'b1;
            ap_addr_d  = {bus.cmd_addr[31:2], 2'b00};
            ap_write_d = bus.cmd_write;
            ap_wdata_d = bus.cmd_wdata;
        end

        if (retire) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = dp_write_q ? '0 : bus.HRDATA;
            rsp_err_d   = bus.HRESP;
        end

        if (tmo) begin
            ap_valid_d  = 1'b0;
            dp_valid_d  = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 32'hDEAD_BEEF;
            rsp_err_d   = 1'b1;
        end

        state_d = state_e'({ap_valid_d, dp_valid_d});
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            ap_addr_q   <= '0;
            ap_write_q  <= 1'b0;
            ap_wdata_q  <= '0;
            dp_write_q  <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ap_addr_q   <= ap_addr_d;
            ap_write_q  <= ap_write_d;
            ap_wdata_q  <= ap_wdata_d;
            dp_write_q  <= dp_write_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.HSEL      = ap_valid && !err_hold;
    assign bus.HTRANS    = (ap_valid && !err_hold) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HADDR     = ap_addr_q;
    assign bus.HWRITE    = ap_write_q;
    assign bus.HWDATA    = hwdata_q;
    assign bus.HSIZE     = 3'b010;
    assign bus.HBURST    = 3'b000;
    assign bus.HPROT     = 4'b0011;
    assign bus.HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahblite_master_engine.sv
// Directed self-checking bench for ahblite_master_engine: cycle-scripted slave and commands with hand-computed expectations.
module tb_ahblite_master_engine;
    logic HCLK = 1'b0;
    logic HRESET;
    int   checks = 0;
    int   passes = 0;

    ahblite_master_engine_if bus ();

    ahblite_master_engine #(.TIMEOUT_CYCLES(8)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus.master)
    );

    always #5 HCLK = ~HCLK;

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.HREADY    = 1'b1;
        bus.HRESP     = 1'b0;
        bus.HRDATA    = '0;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        idle_inputs();
        repeat (3) @(posedge HCLK);
        #1;
        @(negedge HCLK);
        checks++; if (bus.cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready got %b exp 0", bus.cmd_ready); else passes++;
        checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b exp 0", bus.rsp_valid); else passes++;
        checks++; if (bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) $display("FAIL rst_rsp got %h/%b exp 0/0", bus.rsp_rdata, bus.rsp_err); else passes++;
        checks++; if (bus.HSEL !== 1'b0 || bus.HTRANS !== 2'b00) $display("FAIL rst_htrans got %b/%b exp 0/00", bus.HSEL, bus.HTRANS); else passes++;
        checks++; if (bus.HADDR !== 32'h0 || bus.HWRITE !== 1'b0 || bus.HWDATA !== 32'h0) $display("FAIL rst_bus got %h/%b/%h exp 0", bus.HADDR, bus.HWRITE, bus.HWDATA); else passes++;
        checks++; if ({bus.HSIZE, bus.HBURST, bus.HPROT, bus.HMASTLOCK} !== {3'b010, 3'b000, 4'b0011, 1'b0})
            $display("FAIL rst_const got %b %b %b %b exp 010 000 0011 0", bus.HSIZE, bus.HBURST, bus.HPROT, bus.HMASTLOCK); else passes++;
        next_cycle();
        HRESET = 1'b0;
    endtask

    task automatic test_single_write();
        for (int c = 0; c <= 4; c++) begin
            idle_inputs();
            if (c == 0) begin
                bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1;
                bus.cmd_addr = 32'h0000_0010; bus.cmd_wdata = 32'h1234_5678;
            end
            @(negedge HCLK);
            case (c)
                0: begin checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL wr_cmd_ready got %b exp 1", bus.cmd_ready); else passes++; end
                1: begin
                    checks++; if (bus.HTRANS !== 2'b10 || bus.HSEL !== 1'b1) $display("FAIL wr_nonseq got %b/%b exp 10/1", bus.HTRANS, bus.HSEL); else passes++;
                    checks++; if (bus.HADDR !== 32'h10 || bus.HWRITE !== 1'b1) $display("FAIL wr_addr got %h/%b exp 00000010/1", bus.HADDR, bus.HWRITE); else passes++;
                end
                2: begin
                    checks++; if (bus.HWDATA !== 32'h1234_5678) $display("FAIL wr_hwdata got %h exp 12345678", bus.HWDATA); else passes++;
                    checks++; if (bus.HTRANS !== 2'b00 || bus.rsp_valid !== 1'b0) $display("FAIL wr_dp_idle got %b/%b exp 00/0", bus.HTRANS, bus.rsp_valid); else passes++;
                end
                3: begin checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0)
                    $display("FAIL wr_rsp got %b/%b/%h exp 1/0/00000000", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); else passes++; end
                default: begin checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL wr_rsp_once got %b exp 0", bus.rsp_valid); else passes++; end
            endcase
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ad [5] = '{32'h20, 32'h24, 32'h28, 32'h2C, 32'h0F};
        logic [31:0] ex [5] = '{32'h20, 32'h24, 32'h28, 32'h2C, 32'h0C};
        logic [31:0] wd [5] = '{32'h1000, 32'h1001, 32'h1002, 32'h1003, 32'h0};
        logic [31:0] rd_exp;
        for (int c = 0; c <= 8; c++) begin
            idle_inputs();
            bus.HRDATA = 32'hA5A5_0001;
            if (c < 5) begin
                bus.cmd_valid = 1'b1; bus.cmd_write = (c < 4);
                bus.cmd_addr = ad[c]; bus.cmd_wdata = wd[c];
            end
            @(negedge HCLK);
            if (c < 5) begin
                checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL b2b_ready c%0d got %b exp 1", c, bus.cmd_ready); else passes++;
            end
            if (c >= 1 && c <= 5) begin
                checks++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== ex[c-1] || bus.HWRITE !== (c <= 4))
                    $display("FAIL b2b_addr c%0d got %b/%h/%b exp 10/%h/%b", c, bus.HTRANS, bus.HADDR, bus.HWRITE, ex[c-1], (c <= 4)); else passes++;
            end
            if (c >= 2 && c <= 5) begin
                checks++; if (bus.HWDATA !== wd[c-2]) $display("FAIL b2b_hwdata c%0d got %h exp %h", c, bus.HWDATA, wd[c-2]); else passes++;
            end
            if (c >= 3 && c <= 7) begin
                rd_exp = (c == 7) ? 32'hA5A5_0001 : 32'h0;
                checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== rd_exp)
                    $display("FAIL b2b_rsp c%0d got %b/%b/%h exp 1/0/%h", c, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, rd_exp); else passes++;
            end
            if (c == 8) begin
                checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL b2b_rsp_count got %b exp 0", bus.rsp_valid); else passes++;
            end
            next_cycle();
        end
    endtask

    task automatic test_wait_states();
        logic exp_v;
        for (int c = 0; c <= 8; c++) begin
            idle_inputs();
            if (c <= 1) begin
                bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0;
                bus.cmd_addr = (c == 0) ? 32'h100 : 32'h104;
            end
            bus.HREADY = !(c >= 2 && c <= 4);
            bus.HRDATA = (c == 5) ? 32'h1111_AAAA : (c == 6) ? 32'h2222_BBBB : 32'hFFFF_FFFF;
            @(negedge HCLK);
            if (c >= 2 && c <= 4) begin
                checks++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h104)
                    $display("FAIL ws_hold c%0d got %b/%h exp 10/00000104", c, bus.HTRANS, bus.HADDR); else passes++;
                checks++; if (bus.cmd_ready !== 1'b0) $display("FAIL ws_ready c%0d got %b exp 0", c, bus.cmd_ready); else passes++;
            end
            if (c == 5) begin
                checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL ws_ready_resume got %b exp 1", bus.cmd_ready); else passes++;
            end
            if (c >= 2) begin
                exp_v = (c == 6 || c == 7);
                checks++; if (bus.rsp_valid !== exp_v) $display("FAIL ws_rsp_valid c%0d got %b exp %b", c, bus.rsp_valid, exp_v); else passes++;
            end
            if (c == 6) begin
                checks++; if (bus.rsp_rdata !== 32'h1111_AAAA) $display("FAIL ws_rdata1 got %h exp 1111aaaa", bus.rsp_rdata); else passes++;
            end
            if (c == 7) begin
                checks++; if (bus.rsp_rdata !== 32'h2222_BBBB) $display("FAIL ws_rdata2 got %h exp 2222bbbb", bus.rsp_rdata); else passes++;
            end
            next_cycle();
        end
    endtask

    task automatic test_error();
        for (int c = 0; c <= 7; c++) begin
            idle_inputs();
            if (c <= 1) begin
                bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1;
                bus.cmd_addr  = (c == 0) ? 32'h40 : 32'h44;
                bus.cmd_wdata = (c == 0) ? 32'hAAAA_0001 : 32'hBBBB_0002;
            end
            if (c == 2) begin bus.HREADY = 1'b0; bus.HRESP = 1'b1; end
            if (c == 3) begin bus.HREADY = 1'b1; bus.HRESP = 1'b1; end
            @(negedge HCLK);
            case (c)
                1: begin checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL err_ready_c1 got %b exp 1", bus.cmd_ready); else passes++; end
                2: begin
                    checks++; if (bus.HTRANS !== 2'b00 || bus.HSEL !== 1'b0) $display("FAIL err_cancel got %b/%b exp 00/0", bus.HTRANS, bus.HSEL); else passes++;
                    checks++; if (bus.cmd_ready !== 1'b0 || bus.HWDATA !== 32'hAAAA_0001) $display("FAIL err_c2 got %b/%h exp 0/aaaa0001", bus.cmd_ready, bus.HWDATA); else passes++;
                end
                3: begin checks++; if (bus.HTRANS !== 2'b00 || bus.cmd_ready !== 1'b0) $display("FAIL err_c3 got %b/%b exp 00/0", bus.HTRANS, bus.cmd_ready); else passes++; end
                4: begin
                    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1) $display("FAIL err_rsp1 got %b/%b exp 1/1", bus.rsp_valid, bus.rsp_err); else passes++;
                    checks++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h44 || bus.HWRITE !== 1'b1)
                        $display("FAIL err_reissue got %b/%h/%b exp 10/00000044/1", bus.HTRANS, bus.HADDR, bus.HWRITE); else passes++;
                end
                5: begin checks++; if (bus.HWDATA !== 32'hBBBB_0002 || bus.rsp_valid !== 1'b0 || bus.HTRANS !== 2'b00)
                    $display("FAIL err_dp2 got %h/%b/%b exp bbbb0002/0/00", bus.HWDATA, bus.rsp_valid, bus.HTRANS); else passes++; end
                6: begin checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0) $display("FAIL err_rsp2 got %b/%b exp 1/0", bus.rsp_valid, bus.rsp_err); else passes++; end
                7: begin checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL err_no_dup got %b exp 0", bus.rsp_valid); else passes++; end
                default: ;
            endcase
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c <= 9; c++) begin
            idle_inputs();
            if (c <= 1) begin
                bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0;
                bus.cmd_addr = (c == 0) ? 32'h80 : 32'h84;
            end
            if (c == 5) begin
                bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1;
                bus.cmd_addr = 32'h90; bus.cmd_wdata = 32'h5555_AAAA;
            end
            bus.HRDATA = 32'h7777_0000;
            HRESET = (c == 2);
            @(negedge HCLK);
            if (c == 2) begin
                checks++; if (bus.cmd_ready !== 1'b0) $display("FAIL rm_ready got %b exp 0", bus.cmd_ready); else passes++;
            end
            if (c == 3) begin
                checks++; if (bus.HSEL !== 1'b0 || bus.HTRANS !== 2'b00 || bus.HADDR !== 32'h0 || bus.HWRITE !== 1'b0)
                    $display("FAIL rm_addr got %b/%b/%h/%b exp 0/00/0/0", bus.HSEL, bus.HTRANS, bus.HADDR, bus.HWRITE); else passes++;
                checks++; if (bus.HWDATA !== 32'h0 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0)
                    $display("FAIL rm_data got %h/%h/%b exp 0/0/0", bus.HWDATA, bus.rsp_rdata, bus.rsp_err); else passes++;
            end
            if (c >= 2 && c <= 7) begin
                checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rm_no_rsp c%0d got %b exp 0", c, bus.rsp_valid); else passes++;
            end
            if (c == 6) begin
                checks++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h90) $display("FAIL rm_new_addr got %b/%h exp 10/00000090", bus.HTRANS, bus.HADDR); else passes++;
            end
            if (c == 7) begin
                checks++; if (bus.HWDATA !== 32'h5555_AAAA) $display("FAIL rm_new_hwdata got %h exp 5555aaaa", bus.HWDATA); else passes++;
            end
            if (c == 8) begin
                checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0)
                    $display("FAIL rm_new_rsp got %b/%b/%h exp 1/0/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); else passes++;
            end
            next_cycle();
        end
    endtask

`ifdef AHBM_TIMEOUT_EN
    task automatic test_timeout();
        for (int c = 0; c <= 12; c++) begin
            idle_inputs();
            if (c <= 1) begin
                bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0;
                bus.cmd_addr = (c == 0) ? 32'hC0 : 32'hC4;
            end
            bus.HREADY = !(c >= 2 && c <= 9);
            @(negedge HCLK);
            if (c == 9) begin
                checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL to_early got %b exp 0", bus.rsp_valid); else passes++;
            end
            if (c == 10) begin
                checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'hDEAD_BEEF)
                    $display("FAIL to_rsp got %b/%b/%h exp 1/1/deadbeef", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); else passes++;
            end
            if (c >= 10) begin
                checks++; if (bus.HTRANS !== 2'b00 || bus.HSEL !== 1'b0) $display("FAIL to_idle c%0d got %b/%b exp 00/0", c, bus.HTRANS, bus.HSEL); else passes++;
            end
            if (c >= 11) begin
                checks++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1)
                    $display("FAIL to_dropped c%0d got %b/%b exp 0/1", c, bus.rsp_valid, bus.cmd_ready); else passes++;
            end
            next_cycle();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_wait_states();
        test_error();
        test_reset_mid();
`ifdef AHBM_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
